pipe_hazard_ctrl: RTL and testbench

Pipeline hazard and sequencing controller for the five-stage MIPS core. Sits alongside the IF/ID, ID/EX (decode) and EX/MEM (execution) pipeline registers and drives their hold, bubble and flush controls. Its inputs are the decode-stage source registers, the ID/EX load destination, the registered branch-taken flag from the execution stage, and the data-memory handshake. It covers load-use stalls, data-memory wait states with a timeout, and branch flushes, and keeps saturating stall and flush statistics.

---
 rtl/pipe_pkg.sv | 6 +
 rtl/sat_counter.sv | 16 +
 rtl/pipe_hazard_ctrl.sv | 98 +++++++++
 tb/tb_pipe_hazard_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_pkg;
   typedef enum logic [1:0] {RUN, LU_STALL, MEM_WAIT} state_t;
   localparam logic [4:0] REG_ZERO    = 5'd0;
   localparam int         TIMEOUT_DEF = 16;
endpackage

// File: rtl/sat_counter.sv
// Saturating event counter used for the stall/flush statistics.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   input  logic         clear,
   output logic [W-1:0] value
);
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                     value <= '0;
      else if (clear)               value <= '0;
      else if (inc && value != '1)  value <= value + 1'b1;
   end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller: load-use stalls, data-memory wait with
// timeout, branch flushes, and saturating stall/flush statistics.
module pipe_hazard_ctrl
   import pipe_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEF,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       FD_rs,
   input  logic [4:0]       FD_rt,
   input  logic             FD_uses_rt,
   input  logic             DX_MemRead,
   input  logic [4:0]       DX_RD,
   input  logic             XM_branch,
   input  logic             XM_MemRead,
   input  logic             XM_MemWrite,
   input  logic             dmem_ready,
   output logic             PC_write,
   output logic             FD_write,
   output logic             DX_bubble,
   output logic             FD_flush,
   output logic             DX_flush,
   output logic             XM_flush,
   output logic             PC_sel_bt,
   output logic             XM_hold,
   output logic             mem_err,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);
   localparam int WC_W = $clog2(TIMEOUT + 1);

   state_t          state, state_nxt;
   logic [WC_W-1:0] wcnt, wcnt_nxt;
   logic            mem_op, tmo, mw, hz, err_set;

   assign mem_op  = XM_MemRead | XM_MemWrite;
   // Timeout release cycle: the frozen access is let go even without ready.
   assign tmo     = (state == MEM_WAIT) && (wcnt >= WC_W'(TIMEOUT));
   assign mw      = mem_op && !dmem_ready && !tmo;
   assign err_set = tmo && mem_op && !dmem_ready;
   assign hz      = DX_MemRead && (DX_RD != REG_ZERO) &&
                    ((DX_RD == FD_rs) || (FD_uses_rt && (DX_RD == FD_rt)));

   always_comb begin
      PC_write  = 1'b1;
      FD_write  = 1'b1;
      DX_bubble = 1'b0;
      FD_flush  = 1'b0;
      DX_flush  = 1'b0;
      XM_flush  = 1'b0;
      PC_sel_bt = 1'b0;
      XM_hold   = 1'b0;
      state_nxt = RUN;
      wcnt_nxt  = '0;
      // Controls are forced idle while reset is held, regardless of inputs.
      if (rst) begin
         if (mw) begin
            XM_hold   = 1'b1;
            PC_write  = 1'b0;
            FD_write  = 1'b0;
            state_nxt = MEM_WAIT;
            wcnt_nxt  = (state == MEM_WAIT) ? wcnt + 1'b1 : WC_W'(1);
         end else if (XM_branch) begin
            PC_sel_bt = 1'b1;
            FD_flush  = 1'b1;
            DX_flush  = 1'b1;
            XM_flush  = 1'b1;
         end else if (hz && state != LU_STALL) begin
            PC_write  = 1'b0;
            FD_write  = 1'b0;
            DX_bubble = 1'b1;
            state_nxt = LU_STALL;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= RUN;
         wcnt    <= '0;
         mem_err <= 1'b0;
      end else begin
         state <= state_nxt;
         wcnt  <= wcnt_nxt;
         if (err_set) mem_err <= 1'b1;
      end
   end

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk(clk), .rst(rst), .inc(!PC_write), .clear(1'b0), .value(stall_cnt)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk(clk), .rst(rst), .inc(XM_flush), .clear(1'b0), .value(flush_cnt)
   );
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench: directed vector table, hand sequences, random vs model.
module tb_pipe_hazard_ctrl;
   localparam int TO  = 4;
   localparam int CW  = 4;
   localparam int SAT = (1 << CW) - 1;

   logic          clk = 1'b0, rst = 1'b0;
   logic [4:0]    FD_rs, FD_rt, DX_RD;
   logic          FD_uses_rt, DX_MemRead, XM_branch, XM_MemRead, XM_MemWrite, dmem_ready;
   logic          PC_write, FD_write, DX_bubble, FD_flush, DX_flush, XM_flush, PC_sel_bt, XM_hold;
   logic          mem_err;
   logic [CW-1:0] stall_cnt, flush_cnt;

   int n_chk = 0, n_fail = 0;

   // control vector order: {PC_write,FD_write,DX_bubble,FD_flush,DX_flush,XM_flush,PC_sel_bt,XM_hold}
   localparam logic [7:0] C_IDLE  = 8'b1100_0000;
   localparam logic [7:0] C_STALL = 8'b0010_0000;
   localparam logic [7:0] C_FLUSH = 8'b1101_1110;
   localparam logic [7:0] C_HOLD  = 8'b0000_0001;

   pipe_hazard_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .FD_rs(FD_rs), .FD_rt(FD_rt), .FD_uses_rt(FD_uses_rt),
      .DX_MemRead(DX_MemRead), .DX_RD(DX_RD), .XM_branch(XM_branch),
      .XM_MemRead(XM_MemRead), .XM_MemWrite(XM_MemWrite), .dmem_ready(dmem_ready),
      .PC_write(PC_write), .FD_write(FD_write), .DX_bubble(DX_bubble),
      .FD_flush(FD_flush), .DX_flush(DX_flush), .XM_flush(XM_flush),
      .PC_sel_bt(PC_sel_bt), .XM_hold(XM_hold), .mem_err(mem_err),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       dmr;
      logic [4:0] rd, rs, rt;
      logic       urt, br, mr, mwr, rdy;
      logic [7:0] exp;
   } vec_t;

   function automatic logic [7:0] ctl_now();
      return {PC_write, FD_write, DX_bubble, FD_flush, DX_flush, XM_flush, PC_sel_bt, XM_hold};
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic set_in(input logic dmr, input logic [4:0] rd, rs, rt,
                         input logic urt, br, mr, mwr, rdy);
      DX_MemRead = dmr; DX_RD = rd; FD_rs = rs; FD_rt = rt; FD_uses_rt = urt;
      XM_branch = br; XM_MemRead = mr; XM_MemWrite = mwr; dmem_ready = rdy;
   endtask

   task automatic idle_in();
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 1);
   endtask

   // Reference model: held-cycle count of the current access, whether the
   // previous cycle inserted a bubble, and plain integer statistics.
   int m_wait, m_stall, m_flush;
   bit m_lu, m_err;

   task automatic model_clear();
      m_wait = 0; m_stall = 0; m_flush = 0; m_lu = 0; m_err = 0;
   endtask

   task automatic model_eval(output logic [7:0] c, output bit held, output bit err);
      bit mem, hz;
      mem  = XM_MemRead || XM_MemWrite;
      hz   = DX_MemRead && DX_RD != 0 && (DX_RD == FD_rs || (FD_uses_rt && DX_RD == FD_rt));
      held = mem && !dmem_ready && m_wait < TO;
      err  = mem && !dmem_ready && m_wait >= TO;
      if (held)                c = C_HOLD;
      else if (XM_branch)      c = C_FLUSH;
      else if (hz && !m_lu)    c = C_STALL;
      else                     c = C_IDLE;
   endtask

   task automatic model_update(input logic [7:0] c, input bit held, input bit err);
      m_wait = held ? m_wait + 1 : 0;
      m_lu   = c[5];
      if (err) m_err = 1;
      if (!c[7] && m_stall < SAT) m_stall++;
      if (c[2] && m_flush < SAT)  m_flush++;
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b0;
      idle_in();
      @(posedge clk); #1;
      rst = 1'b1;
      model_clear();
   endtask

   task automatic step_chk(input string nm, input logic [7:0] exp);
      @(negedge clk);
      chk(nm, ctl_now(), exp);
      @(posedge clk); #1;
   endtask

   task automatic rnd_cycle();
      logic [7:0] c;
      bit held, err;
      set_in(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom_range(0, 6) == 0,
             $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 9) < 3);
      @(negedge clk);
      model_eval(c, held, err);
      chk("rnd_ctl", ctl_now(), c);
      chk("rnd_mem_err", mem_err, m_err);
      chk("rnd_stall_cnt", stall_cnt, m_stall);
      chk("rnd_flush_cnt", flush_cnt, m_flush);
      @(posedge clk);
      model_update(c, held, err);
      #1;
   endtask

   vec_t vt[10];

   initial begin
      vt[0] = '{dmr:1, rd:5, rs:5, rt:0, urt:0, br:0, mr:0, mwr:0, rdy:1, exp:C_STALL};
      vt[1] = '{dmr:1, rd:0, rs:0, rt:0, urt:1, br:0, mr:0, mwr:0, rdy:1, exp:C_IDLE};
      vt[2] = '{dmr:1, rd:5, rs:1, rt:5, urt:0, br:0, mr:0, mwr:0, rdy:1, exp:C_IDLE};
      vt[3] = '{dmr:1, rd:5, rs:1, rt:5, urt:1, br:0, mr:0, mwr:0, rdy:1, exp:C_STALL};
      vt[4] = '{dmr:0, rd:5, rs:5, rt:5, urt:1, br:0, mr:0, mwr:0, rdy:1, exp:C_IDLE};
      vt[5] = '{dmr:1, rd:5, rs:5, rt:0, urt:0, br:1, mr:0, mwr:0, rdy:1, exp:C_FLUSH};
      vt[6] = '{dmr:0, rd:0, rs:0, rt:0, urt:0, br:0, mr:1, mwr:0, rdy:0, exp:C_HOLD};
      vt[7] = '{dmr:1, rd:7, rs:7, rt:0, urt:0, br:1, mr:0, mwr:1, rdy:0, exp:C_HOLD};
      vt[8] = '{dmr:1, rd:3, rs:0, rt:3, urt:1, br:0, mr:1, mwr:0, rdy:1, exp:C_STALL};
      vt[9] = '{dmr:0, rd:0, rs:0, rt:0, urt:0, br:1, mr:1, mwr:0, rdy:1, exp:C_FLUSH};

      idle_in();
      // reset held with random inputs
      #2;
      for (int i = 0; i < 3; i++) begin
         set_in(1, 5'($urandom_range(1, 3)), 5'($urandom_range(1, 3)), 5'($urandom_range(1, 3)),
                1, 1'($urandom_range(0, 1)), 1, 1'($urandom_range(0, 1)), 0);
         @(negedge clk);
         chk("reset_ctl", ctl_now(), C_IDLE);
         chk("reset_cnts", {mem_err, stall_cnt, flush_cnt}, 0);
      end
      @(posedge clk); #1;
      rst = 1'b1;

      foreach (vt[i]) begin
         do_reset();
         set_in(vt[i].dmr, vt[i].rd, vt[i].rs, vt[i].rt, vt[i].urt,
                vt[i].br, vt[i].mr, vt[i].mwr, vt[i].rdy);
         @(negedge clk);
         chk($sformatf("vec%0d_ctl", i), ctl_now(), vt[i].exp);
      end

      // load-use: exactly one bubble even with the hazard pattern still present
      do_reset();
      set_in(1, 5, 5, 0, 0, 0, 0, 0, 1);
      step_chk("lu_bubble", C_STALL);
      step_chk("lu_no_second", C_IDLE);
      idle_in();
      @(negedge clk);
      chk("lu_stall_cnt", stall_cnt, 1);

      // memory wait of 3 cycles, ready on the 4th
      do_reset();
      set_in(0, 0, 0, 0, 0, 0, 1, 0, 0);
      for (int i = 0; i < 3; i++) step_chk("mw_hold", C_HOLD);
      dmem_ready = 1'b1;
      step_chk("mw_release", C_IDLE);
      idle_in();
      @(negedge clk);
      chk("mw_stall_cnt", stall_cnt, 3);
      chk("mw_no_err", mem_err, 0);

      // timeout: ready never arrives
      do_reset();
      set_in(0, 0, 0, 0, 0, 0, 1, 0, 0);
      for (int i = 0; i < TO; i++) step_chk("to_hold", C_HOLD);
      step_chk("to_release", C_IDLE);
      idle_in();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("to_mem_err_sticky", mem_err, 1);
         @(posedge clk); #1;
      end
      chk("to_stall_cnt", stall_cnt, TO);
      do_reset();
      @(negedge clk);
      chk("to_err_cleared", mem_err, 0);

      // branch with hazard, then saturation of flush_cnt
      do_reset();
      set_in(1, 5, 5, 0, 0, 1, 0, 0, 1);
      step_chk("br_flush", C_FLUSH);
      chk("br_flush_cnt1", flush_cnt, 1);
      for (int i = 0; i < (1 << CW) + 2; i++) step_chk("br_flush_n", C_FLUSH);
      chk("br_flush_sat", flush_cnt, SAT);
      chk("br_no_stall", stall_cnt, 0);

      // reset asserted mid-wait
      do_reset();
      set_in(0, 0, 0, 0, 0, 0, 1, 0, 0);
      step_chk("rw_hold1", C_HOLD);
      step_chk("rw_hold2", C_HOLD);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rw_async_ctl", ctl_now(), C_IDLE);
      chk("rw_async_cnt", stall_cnt, 0);
      @(posedge clk); #1;
      rst = 1'b1;
      set_in(1, 6, 6, 0, 0, 0, 1, 0, 1);
      step_chk("rw_run_hz", C_STALL);

      // randomized against the model
      do_reset();
      for (int i = 0; i < 600; i++) rnd_cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
